seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential integer ALU: single-cycle base ops, iterative shift-add multiply
// and restoring divide, valid/ready handshake with one transaction in flight.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [4:0]           op_q, op_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]     b_q, b_d, o_q, o_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Request decode, valid only while a request is being accepted.
    logic             is_mul, is_div, div_signed, a_signed, b_signed;
    logic             s_a, s_b, b_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, spec_res, base_res;
    logic [SHW-1:0]   shamt;

    assign is_mul     = (op[4:2] == 3'b100);
    assign is_div     = (op[4:2] == 3'b101);
    assign div_signed = ~op[0];
    assign a_signed   = is_div ? div_signed : (op[1:0] != 2'b11);
    assign b_signed   = is_div ? div_signed : (op[1:0] == 2'b01);
    assign s_a        = a_signed & a[WIDTH-1];
    assign s_b        = b_signed & b[WIDTH-1];
    assign a_mag      = s_a ? -a : a;
    assign b_mag      = s_b ? -b : b;
    assign b_zero     = (b == '0);
    assign div_ovf    = div_signed && (a == MIN_NEG) && (b == '1);
    assign spec_res   = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign shamt      = b[SHW-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        base_res = '0;
        if (!op[4]) begin
            casez (op[3:0])
                4'b0010: base_res = a + b;
                4'b0011: base_res = a - b;
                4'b0100: base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                4'b0101: base_res = {{(WIDTH-1){1'b0}}, (a < b)};
                4'b011?: base_res = a ^ b;
                4'b100?: base_res = a << shamt;
                4'b1010: base_res = a >> shamt;
                4'b1011: base_res = $signed(a) >>> shamt;
                4'b110?: base_res = a | b;
                4'b111?: base_res = a & b;
                default: base_res = '0;
            endcase
        end
    end

    // One iteration step: p holds {acc, multiplier} or {remainder, quotient}.
    logic [WIDTH:0]       mul_sum, div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   p_step, prod;
    logic [WIDTH-1:0]     quo, rem, fin_res;

    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = p_q[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        if (state_q == MUL)
            p_step = {mul_sum, p_q[WIDTH-1:1]};
        else if (!div_diff[WIDTH+1])
            p_step = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else
            p_step = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        prod = (sa_q ^ sb_q) ? -p_step : p_step;
        quo  = (sa_q ^ sb_q) ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
        rem  = sa_q ? -p_step[2*WIDTH-1:WIDTH] : p_step[2*WIDTH-1:WIDTH];
        if (op_q[4:2] == 3'b100)
            fin_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        else
            fin_res = op_q[1] ? rem : quo;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    sa_d  = s_a;
                    sb_d  = s_b;
                    b_d   = b_mag;
                    p_d   = {{WIDTH{1'b0}}, a_mag};
                    cnt_d = '0;
                    if (is_mul) begin
                        state_d = MUL;
                    end else if (is_div && !b_zero && !div_ovf) begin
                        state_d = DIV;
                    end else begin
                        state_d = DONE;
                        o_d     = is_div ? spec_res : base_res;
                    end
                end
            end
            MUL, DIV: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    o_d     = fin_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        o         = o_q;
    end
endmodule
